// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: SRAM-like data bus between the MEM-stage controller and the cache/AXI bridge.
interface dmem_access_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [AW-1:0]   data_addr;
  logic [DW/8-1:0] data_wstrb;
  logic [DW-1:0]   data_wdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [DW-1:0]   data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto the data bus, generates stallM,
// holds read data across external stalls and drains transactions killed by a flush.
module dmem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_wen,
  input  logic [1:0]            mem_size,
  input  logic [DW/8-1:0]       mem_sel,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_wdata,
  input  logic                  stall_other,
  input  logic                  flush,
  output logic                  stallM,
  output logic [DW-1:0]         rdataM,
  dmem_access_ctrl_if.master    bus
);
  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE, CANCEL_ADDR, CANCEL_DATA} state_t;
  state_t          state_q, state_d;
  logic            req_wr_q;
  logic [1:0]      req_size_q;
  logic [DW/8-1:0] req_sel_q;
  logic [AW-1:0]   req_addr_q;
  logic [DW-1:0]   req_wdata_q;
  logic [DW-1:0]   rdata_reg_q, rdata_reg_d;
  logic            req, idle, aok, dok;
  assign idle = state_q == IDLE;
  assign aok  = bus.data_addr_ok;
  assign dok  = bus.data_data_ok;
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    stallM      = 1'b0;
    rdataM      = rdata_reg_q;
    rdata_reg_d = rdata_reg_q;
    case (state_q)
      IDLE: begin
        req    = mem_req && !flush;
        stallM = req;
        state_d = req ? (aok ? WAIT_DATA : WAIT_ADDR) : IDLE;
      end
      WAIT_ADDR: begin
        req     = 1'b1;
        stallM  = 1'b1;
        state_d = flush ? (aok ? CANCEL_DATA : CANCEL_ADDR) : (aok ? WAIT_DATA : WAIT_ADDR);
      end
      WAIT_DATA: begin
        stallM      = !dok;
        rdataM      = dok ? bus.data_rdata : rdata_reg_q;
        rdata_reg_d = (dok && !flush) ? bus.data_rdata : rdata_reg_q;
        state_d     = flush ? (dok ? IDLE : CANCEL_DATA) : dok ? (stall_other ? DONE : IDLE) : WAIT_DATA;
      end
      DONE:        state_d = (!stall_other || flush) ? IDLE : DONE;
      // Killed transactions still own the bus until their response drains.
      CANCEL_ADDR: begin
        req     = 1'b1;
        stallM  = mem_req;
        state_d = aok ? CANCEL_DATA : CANCEL_ADDR;
      end
      CANCEL_DATA: begin
        stallM  = mem_req;
        state_d = dok ? IDLE : CANCEL_DATA;
      end
      default:     state_d = IDLE;
    endcase
  end
  assign bus.data_req   = req;
  assign bus.data_wr    = req && (idle ? mem_wen : req_wr_q);
  assign bus.data_size  = req ? (idle ? mem_size : req_size_q) : 2'd0;
  assign bus.data_addr  = req ? (idle ? mem_addr : req_addr_q) : '0;
  assign bus.data_wdata = req ? (idle ? mem_wdata : req_wdata_q) : '0;
  assign bus.data_wstrb = bus.data_wr ? (idle ? mem_sel : req_sel_q) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_wr_q    <= 1'b0;
      req_size_q  <= '0;
      req_sel_q   <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      rdata_reg_q <= rdata_reg_d;
      if (idle && req) begin
        req_wr_q    <= mem_wen;
        req_size_q  <= mem_size;
        req_sel_q   <= mem_sel;
        req_addr_q  <= mem_addr;
        req_wdata_q <= mem_wdata;
      end
    end
  end
endmodule
